stream_rr_arbiter: RTL

- Shares one valid/ready pipeline stage among NUM_REQ upstream requesters using fair round-robin arbitration.
- Winning beat is captured in an internal one-entry output register; the block replaces the single-input pipeline register at merge points.
- Each beat is tagged with its source index for downstream routing and debug.

---
 rtl/stream_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 43 ++++
 rtl/stream_rr_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/stream_arb_pkg.sv
// Shared definitions for the stream round-robin arbiter.
// Holds default sizes, the index-width helper and the packet-lock state type
// used when STREAM_ARB_PKT_LOCK_EN is defined.
package stream_arb_pkg;

    localparam int NUM_REQ_DEFAULT    = 4;
    localparam int DATA_WIDTH_DEFAULT = 32;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } lock_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// The request vector is doubled and every bit below ptr is masked off, so the
// lowest remaining bit is the first requester at or after ptr, wrapping around.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;

    assign dbl = {req, req};

    // Drop doubled-vector bits that sit below the pointer.
    always_comb begin
        masked = '0;
        for (int j = 0; j < 2*N; j++) begin
            masked[j] = dbl[j] && (j >= int'(ptr));
        end
    end

    // The lowest surviving bit wins; scanning downward leaves that one last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (masked[j]) begin
                grant          = '0;
                grant[j % N]   = 1'b1;
                grant_idx      = IW'(j % N);
                any_grant      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of NUM_REQ valid/ready streams into one registered stage.
// Handshake: a beat moves on a port when valid && ready are both high at a
// rising clock edge; valid never waits on ready, ready may look at valid.
// Optional packet locking is enabled by defining STREAM_ARB_PKT_LOCK_EN: a
// requester that wins with last=0 keeps the output until it sends last=1.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int IDX_W      = idx_w(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef STREAM_ARB_PKT_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_last,
    output logic                          out_last,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [IDX_W-1:0]              out_src,
    output logic [IDX_W-1:0]              dbg_rr_ptr,
    output logic                          dbg_locked
);

    logic [IDX_W-1:0]      rr_ptr;
    logic                  accept;
    logic                  xfer;
    logic [NUM_REQ-1:0]    pick_req;
    logic [IDX_W-1:0]      pick_ptr;
    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  any_grant;
    logic [IDX_W-1:0]      idx_inc;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  ptr_load;
    logic                  locked;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req       (pick_req),
        .ptr       (pick_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // The register can take a beat when empty or emptying this cycle.
    assign accept    = !out_valid || out_ready;
    assign req_ready = grant & {NUM_REQ{accept}};
    assign xfer      = any_grant && accept;
    assign idx_inc   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

    // Route the winning requester's payload to the output register.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef STREAM_ARB_PKT_LOCK_EN
    lock_state_t      state;
    lock_state_t      state_next;
    logic [IDX_W-1:0] owner;
    logic             sel_last;

    assign sel_last = req_last[grant_idx];

    // Lock state and packet owner register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            owner <= '0;
        end else begin
            state <= state_next;
            if (xfer && state == ARB_IDLE) owner <= grant_idx;
        end
    end

    // Enter a lock on a non-last beat, leave it on the owner's last beat.
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:   if (xfer && !sel_last) state_next = ARB_LOCKED;
            ARB_LOCKED: if (xfer && sel_last)  state_next = ARB_IDLE;
        endcase
    end

    // While locked only the owner is visible to the picker and the pointer
    // holds; the owner's last beat moves it to owner+1 (grant_idx == owner).
    always_comb begin
        locked   = (state == ARB_LOCKED);
        pick_req = locked ? (req_valid & (NUM_REQ'(1) << owner)) : req_valid;
        pick_ptr = locked ? owner : rr_ptr;
        ptr_load = xfer && (!locked || sel_last);
    end
`else
    // Every beat is arbitrated independently; the pointer moves on each transfer.
    always_comb begin
        locked   = 1'b0;
        pick_req = req_valid;
        pick_ptr = rr_ptr;
        ptr_load = xfer;
    end
`endif

    // Round-robin pointer: only a transfer rotates priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (ptr_load) begin
            rr_ptr <= idx_inc;
        end
    end

    // One-entry output register: load on transfer, empty on drain without refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
`ifdef STREAM_ARB_PKT_LOCK_EN
            out_last  <= 1'b0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= grant_idx;
`ifdef STREAM_ARB_PKT_LOCK_EN
            out_last  <= sel_last;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign dbg_rr_ptr = rr_ptr;
    assign dbg_locked = locked;

endmodule
